// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register feeding the ALU. Captures decoded operands and
//   controls, detects load-use hazards (one-cycle bubble) and forwards results
//   from EX/MEM and MEM/WB into the ALU operands.
// Ports
//   clk, rst_n                     clock, async active-low reset
//   id_*                           decoded instruction fields from ID
//   flush, hold                    squash / freeze requests for the EX slot
//   exmem_*, memwb_*               downstream writeback info for forwarding
//   id_stall                       freeze PC and IF/ID (combinational)
//   ex_valid, ex_rd, ex_ctrl       EX slot status and downstream controls
//   alu_in1, alu_in2, alu_control  ALU operands and operation
//   ex_store_data                  forwarded rt operand for stores
// ----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W+3:0] id_ctrl,
  input  logic              flush,
  input  logic              hold,
  input  logic              exmem_wr,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_wr,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rd,
  output logic [2:0]        ex_ctrl,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [CTRL_W-1:0] alu_control,
  output logic [DATA_W-1:0] ex_store_data
);

  // Contents of the EX slot; an all-zero value is a bubble.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [CTRL_W-1:0] alu_op;
    logic              alu_src;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } ex_slot_t;

  ex_slot_t ex_q;
  ex_slot_t ex_d;
  ex_slot_t id_slot;
  logic     load_use;
  logic [DATA_W-1:0] rt_fwd;

  // Forwarding mux: EX/MEM has priority, register 0 is never forwarded.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [REG_AW-1:0] src,
    input logic [DATA_W-1:0] rf_data,
    input logic              em_wr,
    input logic [REG_AW-1:0] em_rd,
    input logic [DATA_W-1:0] em_res,
    input logic              mw_wr,
    input logic [REG_AW-1:0] mw_rd,
    input logic [DATA_W-1:0] mw_res
  );
    logic [DATA_W-1:0] r;
    r = rf_data;
    if (em_wr && (em_rd != '0) && (em_rd == src)) begin
      r = em_res;
    end else if (mw_wr && (mw_rd != '0) && (mw_rd == src)) begin
      r = mw_res;
    end
    return r;
  endfunction

  // Unpack the ID control bundle into a slot image.
  always_comb begin
    id_slot           = '0;
    id_slot.valid     = id_valid;
    id_slot.rs        = id_rs;
    id_slot.rt        = id_rt;
    id_slot.rd        = id_rd;
    id_slot.rs_data   = id_rs_data;
    id_slot.rt_data   = id_rt_data;
    id_slot.imm       = id_imm;
    id_slot.alu_op    = id_ctrl[CTRL_W+3:4];
    id_slot.alu_src   = id_ctrl[3];
    id_slot.reg_write = id_ctrl[2];
    id_slot.mem_read  = id_ctrl[1];
    id_slot.mem_write = id_ctrl[0];
  end

  // A load in EX whose target is read by the ID instruction.
  always_comb begin
    load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
               ((ex_q.rd == id_rs) || (ex_q.rd == id_rt)) && id_valid;
    id_stall = load_use || hold;
  end

  // Slot update priority: flush, hold, load-use bubble, load.
  always_comb begin
    ex_d = id_slot;
    if (flush) begin
      ex_d = '0;
    end else if (hold) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // Operand delivery to the ALU and downstream stages.
  always_comb begin
    rt_fwd        = fwd(ex_q.rt, ex_q.rt_data, exmem_wr, exmem_rd, exmem_result,
                        memwb_wr, memwb_rd, memwb_result);
    alu_in1       = fwd(ex_q.rs, ex_q.rs_data, exmem_wr, exmem_rd, exmem_result,
                        memwb_wr, memwb_rd, memwb_result);
    alu_in2       = ex_q.alu_src ? ex_q.imm : rt_fwd;
    ex_store_data = rt_fwd;
    ex_valid      = ex_q.valid;
    ex_rd         = ex_q.rd;
    alu_control   = ex_q.alu_op;
    ex_ctrl       = ex_q.valid ? {ex_q.reg_write, ex_q.mem_read, ex_q.mem_write} : 3'b000;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed and random stimulus for id_ex_stage against a behavioural model
//   of the EX slot contents.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [6:0]  id_ctrl;
  logic        flush, hold;
  logic        exmem_wr;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_wr;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        id_stall, ex_valid;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_ctrl;
  logic [31:0] alu_in1, alu_in2, ex_store_data;
  logic [2:0]  alu_control;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .flush(flush), .hold(hold),
    .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_control(alu_control),
    .ex_store_data(ex_store_data)
  );

  // Reference: what instruction currently occupies EX.
  typedef struct {
    bit        v;
    bit [4:0]  rs, rt, rd;
    bit [31:0] rsd, rtd, imm;
    bit [2:0]  op;
    bit        src, rw, mr, mw;
  } slot_t;

  slot_t m;
  slot_t empty_slot;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] ref_fwd(input bit [4:0] src, input bit [31:0] rf);
    if (src == 0) return rf;
    if (exmem_wr && exmem_rd == src) return exmem_result;
    if (memwb_wr && memwb_rd == src) return memwb_result;
    return rf;
  endfunction

  function automatic bit ref_load_use();
    return m.v && m.mr && m.rd != 0 && id_valid && (m.rd == id_rs || m.rd == id_rt);
  endfunction

  // Compare every output against the model, then advance one clock.
  task automatic tick();
    slot_t nx;
    #1;
    if (!rst_n) m = empty_slot;
    check("id_stall", 32'(id_stall), 32'(ref_load_use() || hold));
    check("ex_valid", 32'(ex_valid), 32'(m.v));
    check("ex_rd", 32'(ex_rd), 32'(m.rd));
    check("ex_ctrl", 32'(ex_ctrl), m.v ? 32'({m.rw, m.mr, m.mw}) : 32'd0);
    check("alu_control", 32'(alu_control), 32'(m.op));
    check("alu_in1", alu_in1, ref_fwd(m.rs, m.rsd));
    check("alu_in2", alu_in2, m.src ? m.imm : ref_fwd(m.rt, m.rtd));
    check("store_data", ex_store_data, ref_fwd(m.rt, m.rtd));
    if (!rst_n || flush) nx = empty_slot;
    else if (hold) nx = m;
    else if (ref_load_use()) nx = empty_slot;
    else begin
      nx.v = id_valid; nx.rs = id_rs; nx.rt = id_rt; nx.rd = id_rd;
      nx.rsd = id_rs_data; nx.rtd = id_rt_data; nx.imm = id_imm;
      nx.op = id_ctrl[6:4]; nx.src = id_ctrl[3];
      nx.rw = id_ctrl[2]; nx.mr = id_ctrl[1]; nx.mw = id_ctrl[0];
    end
    @(posedge clk);
    m = nx;
    @(negedge clk);
  endtask

  task automatic set_id(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd,
                        input bit [31:0] rsd, input bit [31:0] rtd, input bit [31:0] imm,
                        input bit [6:0] ctrl);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_ctrl = ctrl;
  endtask

  task automatic clr_fwd();
    exmem_wr = 0; exmem_rd = 0; exmem_result = 0;
    memwb_wr = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  initial begin
    empty_slot = '{default: 0};
    m = empty_slot;
    rst_n = 0; flush = 0; hold = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    clr_fwd();
    @(negedge clk);
    tick();
    rst_n = 1;
    tick();

    // Basic add, no forwarding.
    set_id(1, 5'd1, 5'd2, 5'd4, 32'd5, 32'd7, 32'd99, 7'b000_0_1_0_0);
    tick();
    #1;
    check("t2_in1", alu_in1, 32'd5);
    check("t2_in2", alu_in2, 32'd7);
    check("t2_ctrl", 32'(ex_ctrl), 32'b100);

    // Forward priority on rs=3.
    set_id(1, 5'd3, 5'd2, 5'd4, 32'h33, 32'h44, 32'h0, 7'b010_0_1_0_0);
    tick();
    exmem_wr = 1; exmem_rd = 3; exmem_result = 32'h10;
    memwb_wr = 1; memwb_rd = 3; memwb_result = 32'h20;
    #1;
    check("t3_exmem", alu_in1, 32'h10);
    exmem_wr = 0;
    #1;
    check("t3_memwb", alu_in1, 32'h20);
    tick();

    // $zero never forwarded.
    clr_fwd();
    set_id(1, 5'd0, 5'd0, 5'd4, 32'd0, 32'd0, 32'h0, 7'b000_0_1_0_0);
    tick();
    exmem_wr = 1; exmem_rd = 0; exmem_result = 32'hFF;
    #1;
    check("t4_zero", alu_in1, 32'd0);
    tick();

    // Load-use: lw r8 then dependent on r8.
    clr_fwd();
    set_id(1, 5'd1, 5'd9, 5'd8, 32'h100, 32'h0, 32'd4, 7'b000_1_1_1_0);
    tick();
    set_id(1, 5'd8, 5'd2, 5'd10, 32'hDEAD, 32'd3, 32'h0, 7'b000_0_1_0_0);
    #1;
    check("t5_stall", 32'(id_stall), 32'd1);
    tick();
    #1;
    check("t5_bubble_v", 32'(ex_valid), 32'd0);
    check("t5_bubble_ctrl", 32'(ex_ctrl), 32'd0);
    check("t5_stall_drop", 32'(id_stall), 32'd0);
    tick();
    memwb_wr = 1; memwb_rd = 8; memwb_result = 32'h1234;
    #1;
    check("t5_dep_v", 32'(ex_valid), 32'd1);
    check("t5_dep_in1", alu_in1, 32'h1234);
    clr_fwd();
    tick();

    // Flush beats hold.
    set_id(1, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd0, 7'b001_0_1_0_0);
    tick();
    flush = 1; hold = 1;
    tick();
    #1;
    check("t6_flush", 32'(ex_valid), 32'd0);
    flush = 0; hold = 0;

    // Reset mid-stream for two cycles.
    set_id(1, 5'd1, 5'd2, 5'd3, 32'd11, 32'd12, 32'd0, 7'b011_0_1_0_1);
    tick();
    rst_n = 0;
    tick();
    tick();
    #1;
    check("t1_valid", 32'(ex_valid), 32'd0);
    check("t1_ctrl", 32'(ex_ctrl), 32'd0);
    check("t1_aluc", 32'(alu_control), 32'd0);
    check("t1_in1", alu_in1, 32'd0);
    rst_n = 1;
    tick();

    // Random traffic over a small register range to provoke hazards.
    for (int i = 0; i < 500; i++) begin
      set_id(1'($urandom_range(0, 7) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 7'($urandom));
      flush = ($urandom_range(0, 15) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      exmem_wr = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3)); exmem_result = $urandom;
      memwb_wr = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3)); memwb_result = $urandom;
      rst_n = ($urandom_range(0, 63) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
